// File: rtl/serial_bridge_pkg.sv
// Shared types and constants for the serial MMIO <-> UART bridge.
package serial_bridge_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/serial_rx_fifo.sv
// Small synchronous receive FIFO. The head entry is read combinationally
// from storage; a pop on an empty FIFO is ignored, and a push on a full
// FIFO only lands when a pop frees the slot in the same cycle.
module serial_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);

    logic [7:0]       mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty = (count_r == CNT_ZERO);
    assign full  = (count_r == CNT_FULL);
    assign head  = mem_r[rd_ptr_r];

    // Qualify the raw strobes against the current occupancy.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/serial_uart_bridge.sv
// Processor serial MMIO byte port <-> asynchronous 8N1 UART line pair.
// TX: one-byte holding register feeding a bit shifter.
// RX: 2-flop synchronizer, mid-bit sampling deserializer, small FIFO.
module serial_uart_bridge
    import serial_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 434,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] proc_data_in,
    input  logic       proc_wren_in,
    output logic       proc_ready_out,
    output logic [7:0] proc_data_out,
    output logic       proc_valid_out,
    input  logic       proc_rden_in,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_ONE  = 3'd1;
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    // ---------------- TX path ----------------
    tx_state_t        tx_state_r;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [2:0]       tx_idx_r;
    logic [7:0]       tx_shift_r;
    logic [7:0]       tx_hold_r;
    logic             tx_ready_r;
    logic             tx_line_r;
    logic             tx_load_s;

    assign proc_ready_out = tx_ready_r;
    assign uart_tx_out    = tx_line_r;

    // Shifter takes the held byte when idle or at the very end of a stop bit.
    always_comb begin
        tx_load_s = 1'b0;
        if (!tx_ready_r) begin
            if (tx_state_r == TX_IDLE) begin
                tx_load_s = 1'b1;
            end else if ((tx_state_r == TX_STOP) && (tx_cnt_r == CNT_LAST)) begin
                tx_load_s = 1'b1;
            end else begin
                tx_load_s = 1'b0;
            end
        end else begin
            tx_load_s = 1'b0;
        end
    end

    // Holding register: accept a write only when empty, free it on load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_hold_r  <= 8'h00;
            tx_ready_r <= 1'b1;
        end else if (tx_load_s) begin
            tx_ready_r <= 1'b1;
        end else if (proc_wren_in && tx_ready_r) begin
            tx_hold_r  <= proc_data_in;
            tx_ready_r <= 1'b0;
        end
    end

    // TX bit sequencer: start, 8 data bits LSB first, stop; back-to-back capable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_idx_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_line_r  <= STOP_BIT;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r <= CNT_ZERO;
                    if (tx_load_s) begin
                        tx_shift_r <= tx_hold_r;
                        tx_line_r  <= START_BIT;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r   <= CNT_ZERO;
                        tx_idx_r   <= 3'd0;
                        tx_line_r  <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        tx_state_r <= TX_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r <= CNT_ZERO;
                        if (tx_idx_r == IDX_LAST) begin
                            tx_line_r  <= STOP_BIT;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_idx_r   <= tx_idx_r + IDX_ONE;
                            tx_line_r  <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r <= CNT_ZERO;
                        if (tx_load_s) begin
                            tx_shift_r <= tx_hold_r;
                            tx_line_r  <= START_BIT;
                            tx_state_r <= TX_START;
                        end else begin
                            tx_state_r <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_cnt_r   <= CNT_ZERO;
                    tx_line_r  <= STOP_BIT;
                end
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic             rx_meta_r;
    logic             rx_sync_r;
    rx_state_t        rx_state_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_idx_r;
    logic [7:0]       rx_shift_r;
    logic             rx_push_r;
    logic [7:0]       rx_push_data_r;
    logic             rx_overrun_r;
    logic             rx_frame_err_r;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    assign rx_overrun_out   = rx_overrun_r;
    assign rx_frame_err_out = rx_frame_err_r;
    assign proc_valid_out   = ~fifo_empty_s;

    // Two-flop synchronizer for the asynchronous RX line (idles high).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx_in;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX deserializer: validate start at half-bit, then sample each mid-bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_r     <= RX_IDLE;
            rx_cnt_r       <= CNT_ZERO;
            rx_idx_r       <= 3'd0;
            rx_shift_r     <= 8'h00;
            rx_push_r      <= 1'b0;
            rx_push_data_r <= 8'h00;
            rx_frame_err_r <= 1'b0;
        end else begin
            rx_push_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= CNT_ZERO;
                    if (rx_sync_r == START_BIT) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == CNT_HALF) begin
                        rx_cnt_r <= CNT_ZERO;
                        rx_idx_r <= 3'd0;
                        if (rx_sync_r != START_BIT) begin
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_state_r <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_idx_r == IDX_LAST) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_idx_r <= rx_idx_r + IDX_ONE;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r <= CNT_ZERO;
                        if (rx_sync_r == STOP_BIT) begin
                            rx_push_r      <= 1'b1;
                            rx_push_data_r <= rx_shift_r;
                            rx_state_r     <= RX_IDLE;
                        end else begin
                            rx_frame_err_r <= 1'b1;
                            rx_state_r     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    // A held break must not look like a stream of new start bits.
                    rx_cnt_r <= CNT_ZERO;
                    if (rx_sync_r == STOP_BIT) begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Sticky overrun: a push arrived while full and no pop made room.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_overrun_r <= 1'b0;
        end else if (rx_push_r && fifo_full_s && !proc_rden_in) begin
            rx_overrun_r <= 1'b1;
        end
    end

    serial_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push_r),
        .push_data (rx_push_data_r),
        .pop       (proc_rden_in),
        .head      (proc_data_out),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule
